// File: rtl/rgb_sram_reader.sv
// rgb_sram_reader
// Streams one frame of packed RGB pixels out of an SRAM with a two-cycle read
// latency. Every pixel pair takes three 16-bit words at A, A+1 and A+2:
//   word0 = {R0, G0}, word1 = {B0, R1}, word2 = {G1, B1}
// Each pair is fetched and then handed out as two pixels over a valid/ready
// handshake. Pixel_X advances on every accepted pixel, so ROW_PIXELS is
// assumed to be even and a pair never straddles two rows.
//
// Ports
//   Clock           rising-edge system clock
//   Resetn          synchronous active-low reset
//   Start           one-cycle request to stream a frame, honoured only when idle
//   SRAM_address    read address presented to the SRAM
//   SRAM_read_data  SRAM data, valid two cycles after its address
//   SRAM_we_n       SRAM write enable (active-low), held inactive
//   Pixel_valid     current pixel is available
//   Pixel_ready     consumer accepts the pixel when high together with Pixel_valid
//   Pixel_R/G/B     colour of the current pixel
//   Pixel_X/Y       column / row of the current pixel
//   Busy            high whenever a frame is in progress
//   Frame_done      one-cycle pulse after the last pixel is accepted
module rgb_sram_reader #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter int          ROW_PIXELS = 320,
    parameter int          ROWS       = 240
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        Pixel_valid,
    input  logic        Pixel_ready,
    output logic [7:0]  Pixel_R,
    output logic [7:0]  Pixel_G,
    output logic [7:0]  Pixel_B,
    output logic [8:0]  Pixel_X,
    output logic [7:0]  Pixel_Y,
    output logic        Busy,
    output logic        Frame_done
);

    localparam int                PAIRS     = ROW_PIXELS * ROWS / 2;
    localparam int                PAIR_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PAIRS - 1);
    localparam logic [8:0]        LAST_COL  = 9'(ROW_PIXELS - 1);
    localparam logic [7:0]        LAST_ROW  = 8'(ROWS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_CAP1,
        S_CAP2,
        S_EMIT_EVEN,
        S_EMIT_ODD,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [PAIR_W-1:0] pair_count;
    logic [15:0]       word0;
    logic [15:0]       word1;
    logic [15:0]       word2;

    // The block never writes to the SRAM.
    assign SRAM_we_n = 1'b1;

    // State register.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs. Any unused encoding falls back to idle.
    always_comb begin
        next_state  = state;
        Pixel_valid = 1'b0;
        Busy        = (state != S_IDLE);
        Frame_done  = 1'b0;
        case (state)
            S_IDLE:      if (Start) next_state = S_RD0;
            S_RD0:       next_state = S_RD1;
            S_RD1:       next_state = S_RD2;
            S_RD2:       next_state = S_CAP1;
            S_CAP1:      next_state = S_CAP2;
            S_CAP2:      next_state = S_EMIT_EVEN;
            S_EMIT_EVEN: begin
                Pixel_valid = 1'b1;
                if (Pixel_ready) next_state = S_EMIT_ODD;
            end
            S_EMIT_ODD: begin
                Pixel_valid = 1'b1;
                if (Pixel_ready) begin
                    next_state = (pair_count < LAST_PAIR) ? S_RD0 : S_DONE;
                end
            end
            S_DONE: begin
                Frame_done = 1'b1;
                next_state = S_IDLE;
            end
            default:     next_state = S_IDLE;
        endcase
    end

    // Address generation, word capture and pixel registers. The address moves
    // ahead during RD0/RD1 and stays on A+2 until the pair is released, so the
    // last pair leaves it on the final word instead of stepping past it.
    // Data returns two cycles after its address, so word0 arrives while in
    // RD2, word1 in CAP1 and word2 in CAP2.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            SRAM_address <= '0;
            pair_count   <= '0;
            word0        <= '0;
            word1        <= '0;
            word2        <= '0;
            Pixel_R      <= '0;
            Pixel_G      <= '0;
            Pixel_B      <= '0;
            Pixel_X      <= '0;
            Pixel_Y      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        SRAM_address <= RGB_BASE;
                        pair_count   <= '0;
                        Pixel_X      <= '0;
                        Pixel_Y      <= '0;
                    end
                end
                S_RD0, S_RD1: SRAM_address <= SRAM_address + 18'd1;
                S_RD2:        word0 <= SRAM_read_data;
                S_CAP1:       word1 <= SRAM_read_data;
                S_CAP2: begin
                    word2   <= SRAM_read_data;
                    Pixel_R <= word0[15:8];
                    Pixel_G <= word0[7:0];
                    Pixel_B <= word1[15:8];
                end
                S_EMIT_EVEN: begin
                    if (Pixel_ready) begin
                        Pixel_R <= word1[7:0];
                        Pixel_G <= word2[15:8];
                        Pixel_B <= word2[7:0];
                        Pixel_X <= Pixel_X + 9'd1;
                    end
                end
                S_EMIT_ODD: begin
                    if (Pixel_ready) begin
                        if (Pixel_X == LAST_COL) begin
                            Pixel_X <= '0;
                            Pixel_Y <= (Pixel_Y == LAST_ROW) ? 8'd0 : Pixel_Y + 8'd1;
                        end else begin
                            Pixel_X <= Pixel_X + 9'd1;
                        end
                        if (pair_count < LAST_PAIR) begin
                            pair_count   <= pair_count + PAIR_W'(1);
                            SRAM_address <= SRAM_address + 18'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_sram_reader.sv
// tb_rgb_sram_reader
// Self-checking bench for rgb_sram_reader. A behavioural SRAM with two-cycle
// read latency feeds the reader; expected pixels are computed from the SRAM
// contents and queued when a frame is started, then popped and compared on
// every accepted handshake. The frame is shortened to 4 rows and placed so
// that its last word sits at 18'h3FFFF, keeping full-frame runs short.
module tb_rgb_sram_reader;

    localparam int          ROW_PIXELS = 320;
    localparam int          ROWS       = 4;
    localparam int          PIXELS     = ROW_PIXELS * ROWS;
    localparam logic [17:0] RGB_BASE   = 18'(262144 - (3 * PIXELS) / 2);
    localparam int          FRAME_WAIT = 20000;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [8:0] x;
        logic [7:0] y;
    } pixel_t;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start;
    logic        Pixel_ready;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic        SRAM_we_n;
    logic        Pixel_valid;
    logic [7:0]  Pixel_R;
    logic [7:0]  Pixel_G;
    logic [7:0]  Pixel_B;
    logic [8:0]  Pixel_X;
    logic [7:0]  Pixel_Y;
    logic        Busy;
    logic        Frame_done;

    pixel_t      exp_q[$];
    pixel_t      exp_pix;
    pixel_t      got_pix;
    int          checks     = 0;
    int          errors     = 0;
    int          accepted   = 0;
    int          done_count = 0;
    bit          sb_on      = 1'b0;
    logic [17:0] addr_d1    = '0;
    logic [17:0] addr_d2    = '0;
    logic [17:0] last_busy_addr = '0;

    rgb_sram_reader #(
        .RGB_BASE  (RGB_BASE),
        .ROW_PIXELS(ROW_PIXELS),
        .ROWS      (ROWS)
    ) dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .Start         (Start),
        .SRAM_address  (SRAM_address),
        .SRAM_read_data(SRAM_read_data),
        .SRAM_we_n     (SRAM_we_n),
        .Pixel_valid   (Pixel_valid),
        .Pixel_ready   (Pixel_ready),
        .Pixel_R       (Pixel_R),
        .Pixel_G       (Pixel_G),
        .Pixel_B       (Pixel_B),
        .Pixel_X       (Pixel_X),
        .Pixel_Y       (Pixel_Y),
        .Busy          (Busy),
        .Frame_done    (Frame_done)
    );

    always #5 Clock = ~Clock;

    // SRAM contents: the first three words are fixed, the rest are hashed.
    function automatic logic [15:0] sram_word(input logic [17:0] a);
        logic [15:0] w;
        if (a == RGB_BASE)              w = 16'h1122;
        else if (a == RGB_BASE + 18'd1) w = 16'h3344;
        else if (a == RGB_BASE + 18'd2) w = 16'h5566;
        else                            w = 16'(a[15:0] * 16'd40503) ^ {14'd0, a[17:16]};
        return w;
    endfunction

    // Reference pixel p of the frame, decoded from the packed word layout.
    function automatic pixel_t expected_pixel(input int p);
        logic [17:0] a;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        pixel_t      e;
        a  = RGB_BASE + 18'(3 * (p / 2));
        w0 = sram_word(a);
        w1 = sram_word(a + 18'd1);
        w2 = sram_word(a + 18'd2);
        if (p % 2 == 0) begin
            e.r = w0[15:8];
            e.g = w0[7:0];
            e.b = w1[15:8];
        end else begin
            e.r = w1[7:0];
            e.g = w2[15:8];
            e.b = w2[7:0];
        end
        e.x = 9'(p % ROW_PIXELS);
        e.y = 8'(p / ROW_PIXELS);
        return e;
    endfunction

    // Two-stage address pipe gives data two cycles after the address.
    always @(posedge Clock) begin
        addr_d1 <= SRAM_address;
        addr_d2 <= addr_d1;
    end
    assign SRAM_read_data = sram_word(addr_d2);

    // Scoreboard side: every handshake pops one expected pixel.
    always @(negedge Clock) begin
        if (sb_on && Resetn === 1'b1 && Pixel_valid === 1'b1 && Pixel_ready === 1'b1) begin
            checks++;
            got_pix = {Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y};
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL pixel_extra: got X=%0d Y=%0d, required no further pixel",
                         Pixel_X, Pixel_Y);
            end else begin
                exp_pix = exp_q.pop_front();
                if (got_pix !== exp_pix) begin
                    errors++;
                    $display("[TB] FAIL pixel_%0d: got R=%h G=%h B=%h X=%0d Y=%0d, required R=%h G=%h B=%h X=%0d Y=%0d",
                             accepted, got_pix.r, got_pix.g, got_pix.b, got_pix.x, got_pix.y,
                             exp_pix.r, exp_pix.g, exp_pix.b, exp_pix.x, exp_pix.y);
                end
            end
            accepted++;
        end
        if (Frame_done === 1'b1) done_count++;
        if (Busy === 1'b1) last_busy_addr = SRAM_address;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
    endtask

    task automatic push_frame();
        exp_q.delete();
        for (int p = 0; p < PIXELS; p++) exp_q.push_back(expected_pixel(p));
    endtask

    task automatic test_reset();
        Resetn      = 1'b0;
        Start       = 1'b0;
        Pixel_ready = 1'b0;
        tick(3);
        checks++;
        if ({SRAM_address, SRAM_we_n, Pixel_valid, Busy, Frame_done} !== {18'd0, 1'b1, 3'b000}) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got addr=%h we_n=%b valid=%b busy=%b done=%b, required 0 1 0 0 0",
                     SRAM_address, SRAM_we_n, Pixel_valid, Busy, Frame_done);
        end
        checks++;
        if ({Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y} !== 41'd0) begin
            errors++;
            $display("[TB] FAIL reset_pixel: got R=%h G=%h B=%h X=%0d Y=%0d, required all 0",
                     Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y);
        end
        Resetn = 1'b1;
        tick(5);
        checks++;
        if ({SRAM_address, SRAM_we_n, Pixel_valid, Busy, Frame_done} !== {18'd0, 1'b1, 3'b000}) begin
            errors++;
            $display("[TB] FAIL idle_ctrl: got addr=%h we_n=%b valid=%b busy=%b done=%b, required 0 1 0 0 0",
                     SRAM_address, SRAM_we_n, Pixel_valid, Busy, Frame_done);
        end
        checks++;
        if ({Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y} !== 41'd0) begin
            errors++;
            $display("[TB] FAIL idle_pixel: got R=%h G=%h B=%h X=%0d Y=%0d, required all 0",
                     Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y);
        end
    endtask

    task automatic test_latency();
        int early;
        push_frame();
        accepted    = 0;
        done_count  = 0;
        sb_on       = 1'b1;
        Pixel_ready = 1'b1;
        pulse_start();
        checks++;
        if (Busy !== 1'b1 || SRAM_address !== RGB_BASE) begin
            errors++;
            $display("[TB] FAIL start_load: got busy=%b addr=%h, required 1 %h", Busy, SRAM_address, RGB_BASE);
        end
        early = (Pixel_valid !== 1'b0) ? 1 : 0;
        for (int i = 2; i <= 5; i++) begin
            tick(1);
            if (Pixel_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("[TB] FAIL latency_early: got %0d early valid cycles, required 0", early);
        end
        tick(1);
        checks++;
        if ({Pixel_valid, Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y} !== {1'b1, 8'h11, 8'h22, 8'h33, 9'd0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL latency_pixel0: got v=%b R=%h G=%h B=%h X=%0d Y=%0d, required 1 11 22 33 0 0",
                     Pixel_valid, Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y);
        end
        tick(1);
        checks++;
        if ({Pixel_valid, Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y} !== {1'b1, 8'h44, 8'h55, 8'h66, 9'd1, 8'd0}) begin
            errors++;
            $display("[TB] FAIL latency_pixel1: got v=%b R=%h G=%h B=%h X=%0d Y=%0d, required 1 44 55 66 1 0",
                     Pixel_valid, Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y);
        end
        checks++;
        if (SRAM_we_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL we_n: got %b, required 1", SRAM_we_n);
        end
    endtask

    // Sits in the odd emit of pair 0; Start pulses land in EMIT_ODD and RD0.
    task automatic test_start_ignored();
        pulse_start();
        checks++;
        if (Busy !== 1'b1 || SRAM_address !== RGB_BASE + 18'd3) begin
            errors++;
            $display("[TB] FAIL start_ignored_odd: got busy=%b addr=%h, required 1 %h",
                     Busy, SRAM_address, RGB_BASE + 18'd3);
        end
        pulse_start();
        checks++;
        if (Busy !== 1'b1 || SRAM_address !== RGB_BASE + 18'd4) begin
            errors++;
            $display("[TB] FAIL start_ignored_rd0: got busy=%b addr=%h, required 1 %h",
                     Busy, SRAM_address, RGB_BASE + 18'd4);
        end
    endtask

    task automatic test_backpressure();
        int     n;
        bit     stable;
        logic [58:0] snap;
        n = 0;
        while (!(Pixel_valid === 1'b1 && Pixel_X[0] === 1'b0) && n < 50) begin
            tick(1);
            n++;
        end
        Pixel_ready = 1'b0;
        checks++;
        if (Pixel_valid !== 1'b1 || Pixel_X !== 9'd2 || Pixel_Y !== 8'd0) begin
            errors++;
            $display("[TB] FAIL bp_entry: got v=%b X=%0d Y=%0d, required 1 2 0", Pixel_valid, Pixel_X, Pixel_Y);
        end
        snap   = {Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y, SRAM_address};
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (Pixel_valid !== 1'b1 || {Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y, SRAM_address} !== snap)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("[TB] FAIL bp_hold: got v=%b outputs=%h, required 1 %h", Pixel_valid,
                     {Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y, SRAM_address}, snap);
        end
        Pixel_ready = 1'b1;
    endtask

    task automatic test_row_wrap();
        int n;
        n = 0;
        while (!(Pixel_valid === 1'b1 && Pixel_X === 9'd319 && Pixel_Y === 8'd0) && n < 3000) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("[TB] FAIL wrap_reach: got timeout, required pixel X=319 Y=0");
        end
        tick(1);
        n = 0;
        while (Pixel_valid !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (Pixel_valid !== 1'b1 || Pixel_X !== 9'd0 || Pixel_Y !== 8'd1) begin
            errors++;
            $display("[TB] FAIL row_wrap: got v=%b X=%0d Y=%0d, required 1 0 1", Pixel_valid, Pixel_X, Pixel_Y);
        end
    endtask

    task automatic test_full_frame();
        int n;
        n = 0;
        while (Frame_done !== 1'b1 && n < FRAME_WAIT) begin
            tick(1);
            n++;
        end
        checks++;
        if (Frame_done !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_done: got done=%b busy=%b, required 1 1", Frame_done, Busy);
        end
        checks++;
        if (accepted != PIXELS || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL frame_count: got %0d handshakes (%0d left), required %0d (0 left)",
                     accepted, exp_q.size(), PIXELS);
        end
        checks++;
        if (last_busy_addr !== 18'h3FFFF || SRAM_address !== 18'h3FFFF) begin
            errors++;
            $display("[TB] FAIL last_addr: got %h/%h, required 3ffff", last_busy_addr, SRAM_address);
        end
        tick(1);
        checks++;
        if (Busy !== 1'b0 || Frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_fall: got busy=%b done=%b, required 0 0", Busy, Frame_done);
        end
        tick(3);
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("[TB] FAIL done_pulses: got %0d, required 1", done_count);
        end
    endtask

    task automatic test_mid_frame_reset();
        int n;
        push_frame();
        accepted   = 0;
        done_count = 0;
        pulse_start();
        n = 0;
        while (!(Pixel_valid === 1'b1 && accepted == 1000) && n < FRAME_WAIT) begin
            tick(1);
            n++;
        end
        checks++;
        if (Pixel_valid !== 1'b1 || accepted != 1000) begin
            errors++;
            $display("[TB] FAIL mid_reach: got v=%b accepted=%0d, required 1 1000", Pixel_valid, accepted);
        end
        Resetn = 1'b0;
        tick(1);
        checks++;
        if ({Pixel_valid, Busy, Frame_done, SRAM_address, Pixel_R, Pixel_G, Pixel_B, Pixel_X, Pixel_Y} !== 62'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got v=%b busy=%b done=%b addr=%h X=%0d Y=%0d, required all 0",
                     Pixel_valid, Busy, Frame_done, SRAM_address, Pixel_X, Pixel_Y);
        end
        Resetn = 1'b1;
        tick(2);
        push_frame();
        accepted = 0;
        pulse_start();
        checks++;
        if (Busy !== 1'b1 || SRAM_address !== RGB_BASE) begin
            errors++;
            $display("[TB] FAIL restart_addr: got busy=%b addr=%h, required 1 %h", Busy, SRAM_address, RGB_BASE);
        end
        n = 0;
        while (Frame_done !== 1'b1 && n < FRAME_WAIT) begin
            tick(1);
            n++;
        end
        checks++;
        if (Frame_done !== 1'b1 || accepted != PIXELS || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL restart_frame: got done=%b handshakes=%0d left=%0d, required 1 %0d 0",
                     Frame_done, accepted, exp_q.size(), PIXELS);
        end
        tick(2);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_start_ignored();
        test_backpressure();
        test_row_wrap();
        test_full_frame();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Last-resort guard in case the sequence above stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rgb_sram_reader.md
RGB_SRAM_READER -- requirements
Module: rgb_sram_reader

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-low.
REQ-002 Parameter RGB_BASE, default 18'd146944: SRAM word address of the first packed RGB word.
REQ-003 Parameter ROW_PIXELS, default 320: pixels per row.
REQ-004 Parameter ROWS, default 240: rows per frame.
REQ-005 Clock  input  1  rising-edge system clock.
REQ-006 Resetn  input  1  synchronous active-low reset, sampled on the rising edge of Clock.
REQ-007 Start  input  1  one-cycle request to stream one frame; sampled only in S_IDLE.
REQ-008 SRAM_address  output  18  read address presented to SRAM.
REQ-009 SRAM_read_data  input  16  SRAM read data, valid 2 cycles after the address is presented.
REQ-010 SRAM_we_n  output  1  SRAM write enable, active-low; this block only reads.
REQ-011 Pixel_valid  output  1  output pixel available.
REQ-012 Pixel_ready  input  1  consumer accepts the pixel when high together with Pixel_valid.
REQ-013 Pixel_R, Pixel_G, Pixel_B  output  8 each  colour of the current pixel.
REQ-014 Pixel_X  output  9  column of the current pixel, 0..ROW_PIXELS-1.
REQ-015 Pixel_Y  output  8  row of the current pixel, 0..ROWS-1.
REQ-016 Busy  output  1  high in every state except S_IDLE.
REQ-017 Frame_done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-018 The state machine SHALL have states S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP1, S_CAP2, S_EMIT_EVEN, S_EMIT_ODD and S_DONE; every state not listed SHALL go to S_IDLE.
REQ-019 Frame format: 3 words per pixel pair at addresses A, A+1, A+2.
- word0 = {R0[15:8], G0[7:0]}
- word1 = {B0[15:8], R1[7:0]}
- word2 = {G1[15:8], B1[7:0]}
REQ-020 S_IDLE with Start=1 SHALL load SRAM_address=RGB_BASE and pair counter=0, then go to S_RD0.
REQ-021 Fetch sequence:
- S_RD0 presents A and goes to S_RD1.
- S_RD1 presents A+1 and goes to S_RD2.
- S_RD2 presents A+2, captures word0 and goes to S_CAP1.
- S_CAP1 captures word1 and goes to S_CAP2.
- S_CAP2 captures word2 and goes to S_EMIT_EVEN.
REQ-022 Pixel_valid SHALL be high only in S_EMIT_EVEN (pixel 0 of the pair) and S_EMIT_ODD (pixel 1 of the pair).
REQ-023 Latency: Pixel_valid SHALL first rise 6 rising edges after the edge that samples Start, counting that edge.
REQ-024 Handshake in the emit states:
- While Pixel_ready=0, Pixel_R/G/B/X/Y SHALL hold stable.
- Pixel_valid=1 and Pixel_ready=1 in S_EMIT_EVEN SHALL move to S_EMIT_ODD.
- Pixel_valid=1 and Pixel_ready=1 in S_EMIT_ODD SHALL advance the pair.
REQ-025 Advancing a pair SHALL increment Pixel_X; at ROW_PIXELS-1 it SHALL wrap to 0 and increment Pixel_Y.
REQ-026 Pair advance from S_EMIT_ODD:
- If the pair counter is below ROW_PIXELS*ROWS/2-1 (38399): increment it, set SRAM_address=A+3, go to S_RD0.
- Otherwise: go to S_DONE.
REQ-027 S_DONE SHALL assert Frame_done for exactly one cycle and go to S_IDLE.
REQ-028 The last address read SHALL be 18'h3FFFF (RGB_BASE+115199); SRAM_address SHALL never wrap or exceed this value.
REQ-029 Start while Busy=1 SHALL be ignored.
REQ-030 Start arriving in the same cycle as the S_DONE pulse SHALL be ignored; Start is sampled only in S_IDLE.
REQ-031 SRAM_we_n SHALL be 1 at all times.

Reset
REQ-032 Resetn=0 at any rising edge, including mid-frame, SHALL set all of the following on that edge and discard any partially fetched pair:
- state = S_IDLE
- SRAM_address = 0, SRAM_we_n = 1
- Pixel_valid = 0, Pixel_R/G/B = 0, Pixel_X = 0, Pixel_Y = 0
- Busy = 0, Frame_done = 0
- pair counter = 0
REQ-033 After reset is released, outputs SHALL stay at their reset values until Start is sampled.

Verification
REQ-034 The bench SHALL cover these scenarios:
- Latency: SRAM words 146944..146946 = 16'h1122, 16'h3344, 16'h5566; Start pulse with Pixel_ready=1 -> pixel (0,0)=R11 G22 B33 on the 6th edge, next cycle pixel (1,0)=R44 G55 B66.
- Backpressure: Pixel_ready=0 for 10 cycles in S_EMIT_EVEN -> Pixel_valid stays 1, outputs constant, SRAM_address unchanged.
- Row wrap: accept pixel X=319, Y=0 -> next pixel X=0, Y=1.
- Full frame: Pixel_ready=1 throughout -> exactly 76800 handshakes, last read address 18'h3FFFF, one Frame_done pulse, Busy falls next cycle.
- Mid-frame reset: Resetn=0 at pixel 1000 -> next cycle Pixel_valid=0, Busy=0; a new Start restarts at address 146944, pixel (0,0).
- Start ignored: second Start while Busy=1 -> no restart, pixel sequence unchanged.
